// File: rtl/truth_table_pkg.sv
// rtl/truth_table_pkg.sv - shared states and defaults for the truth table checker
package truth_table_pkg;

    localparam int N_IN_DEFAULT          = 3;
    localparam int SETTLE_CYCLES_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    function automatic int tt_bits(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - clear/enable counter flagging the last settle cycle
module settle_timer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [CW-1:0] count;

    // Wrap on the final settle cycle is harmless: the sample cycle clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && (count == CW'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - sweeps a Boolean function and checks its truth table
module truth_table_checker
    import truth_table_pkg::*;
#(
    parameter int N_IN          = N_IN_DEFAULT,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [tt_bits(N_IN)-1:0] exp_tt,
    input  logic                     f_in,
    output logic [N_IN-1:0]          stim,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [tt_bits(N_IN)-1:0] tt_out,
    output logic [tt_bits(N_IN)-1:0] err_mask,
    output logic [N_IN:0]            err_count
);

    localparam int              TT_W     = tt_bits(N_IN);
    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(TT_W - 1);

    state_t          state_q;
    state_t          state_d;
    logic [TT_W-1:0] exp_q;
    logic            start_ok;
    logic            sampling;
    logic            last_vec;
    logic            mismatch;
    logic            timer_clear;
    logic            timer_en;
    logic            timer_expired;

    assign start_ok    = (state_q == IDLE) && start;
    assign sampling    = (state_q == SAMPLE);
    assign last_vec    = (stim == LAST_VEC);
    assign mismatch    = f_in ^ exp_q[stim];
    assign timer_clear = start_ok || sampling;
    assign timer_en    = (state_q == SETTLE);
    assign busy        = (state_q != IDLE);

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_en),
        .expired(timer_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SETTLE;
            SETTLE:  if (timer_expired) state_d = SAMPLE;
            SAMPLE:  state_d = last_vec ? IDLE : SETTLE;
            default: state_d = IDLE;
        endcase
    end

    // f_in is sampled raw: the function under test is combinational on stim.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q     <= '0;
            stim      <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            tt_out    <= '0;
            err_mask  <= '0;
            err_count <= '0;
        end else begin
            done <= 1'b0;
            if (start_ok) begin
                exp_q     <= exp_tt;
                stim      <= '0;
                pass      <= 1'b0;
                tt_out    <= '0;
                err_mask  <= '0;
                err_count <= '0;
            end else if (sampling) begin
                tt_out[stim]   <= f_in;
                err_mask[stim] <= mismatch;
                if (mismatch) begin
                    err_count <= err_count + (N_IN + 1)'(1);
                end
                if (last_vec) begin
                    stim <= '0;
                    done <= 1'b1;
                    pass <= (err_count == '0) && !mismatch;
                end else begin
                    stim <= stim + N_IN'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// tb/tb_truth_table_checker.sv - self-checking bench for truth_table_checker
module tb_truth_table_checker;

    localparam int P_A   = 5;
    localparam int TOT_A = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    logic [7:0] exp_tt_a;
    logic [3:0] exp_tt_b;
    logic       f_in_a, f_in_b;
    logic [2:0] stim_a;
    logic [1:0] stim_b;
    logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [7:0] tt_a, mask_a;
    logic [3:0] tt_b, mask_b;
    logic [3:0] cnt_a;
    logic [2:0] cnt_b;
    int         func_sel = 0;
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;

    always #5 clk = ~clk;

    assign f_in_a = (func_sel == 1) ? 1'b1 : ((stim_a[2] & stim_a[1]) | stim_a[0]);
    assign f_in_b = stim_b[1] ^ stim_b[0];

    truth_table_checker dut_a (
        .clk(clk), .rst(rst), .start(start_a), .exp_tt(exp_tt_a), .f_in(f_in_a),
        .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .tt_out(tt_a), .err_mask(mask_a), .err_count(cnt_a)
    );

    truth_table_checker #(.N_IN(2), .SETTLE_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .exp_tt(exp_tt_b), .f_in(f_in_b),
        .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .tt_out(tt_b), .err_mask(mask_b), .err_count(cnt_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic fa(input int i);
        if (func_sel == 1) return 1'b1;
        return ((((i >> 2) & (i >> 1)) | i) & 1) == 1;
    endfunction

    // Timeline model of dut_a: outputs follow from the number of edges since start.
    logic       m_busy = 0, m_done = 0, m_pass = 0;
    int         m_t = 0;
    int         m_cnt = 0;
    logic [7:0] m_exp = 0, m_tt = 0, m_mask = 0;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (rst) begin
            m_busy = 0; m_done = 0; m_pass = 0; m_t = 0; m_cnt = 0;
            m_exp = 0; m_tt = 0; m_mask = 0;
        end else if (!m_busy) begin
            m_done = 0;
            if (start_a) begin
                m_busy = 1; m_t = 0; m_exp = exp_tt_a;
                m_tt = 0; m_mask = 0; m_cnt = 0; m_pass = 0;
            end
        end else begin
            m_t++;
            if (m_t % P_A == 0) begin
                int  i;
                logic b;
                i = m_t / P_A - 1;
                b = fa(i);
                m_tt[i] = b;
                m_mask[i] = b ^ m_exp[i];
                if (b != m_exp[i]) m_cnt++;
            end
            if (m_t == TOT_A) begin
                m_busy = 0; m_done = 1; m_pass = (m_cnt == 0);
            end
        end
        check("stim", stim_a, m_busy ? m_t / P_A : 0);
        check("busy", busy_a, m_busy);
        check("done", done_a, m_done);
        check("pass", pass_a, m_pass);
        check("tt_out", tt_a, m_tt);
        check("err_mask", mask_a, m_mask);
        check("err_count", cnt_a, m_cnt);
    end

    task automatic start_sweep_a(input logic [7:0] e, output int k);
        @(negedge clk);
        exp_tt_a = e;
        start_a  = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        k = cyc;
    endtask

    task automatic wait_done(input int which, output int at);
        at = -1;
        for (int j = 0; j < 80; j++) begin
            @(posedge clk);
            #2;
            if ((which == 0 && done_a) || (which == 1 && done_b)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: dut %0d no done within 80 cycles", which);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, t, t2;
        rst = 1'b1; start_a = 0; start_b = 0; exp_tt_a = 0; exp_tt_b = 0;
        repeat (3) @(negedge clk);
        check("rst_stim", stim_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_tt", tt_a, 0);
        check("rst_b_busy", busy_b, 0);
        rst = 1'b0;

        start_sweep_a(8'hEA, k);
        wait_done(0, t);
        check("t1_latency", t - k, 40);
        check("t1_pass", pass_a, 1);
        check("t1_tt", tt_a, 8'hEA);
        check("t1_mask", mask_a, 8'h00);
        check("t1_cnt", cnt_a, 0);
        check("t1_model_tt", m_tt, 8'hEA);

        start_sweep_a(8'hE8, k);
        wait_done(0, t);
        check("t2_latency", t - k, 40);
        check("t2_pass", pass_a, 0);
        check("t2_mask", mask_a, 8'h02);
        check("t2_cnt", cnt_a, 1);

        func_sel = 1;
        start_sweep_a(8'h00, k);
        wait_done(0, t);
        check("t3_tt", tt_a, 8'hFF);
        check("t3_mask", mask_a, 8'hFF);
        check("t3_cnt", cnt_a, 8);
        check("t3_pass", pass_a, 0);

        func_sel = 0;
        start_sweep_a(8'hEA, k);
        repeat (9) @(negedge clk);
        exp_tt_a = 8'h00;
        start_a  = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(0, t);
        check("t4_latency", t - k, 40);
        check("t4_pass", pass_a, 1);
        check("t4_tt", tt_a, 8'hEA);
        check("t4_mask", mask_a, 8'h00);

        start_sweep_a(8'hEA, k);
        repeat (16) @(negedge clk);
        check("t5_stim_before", stim_a, 3);
        check("t5_tt_before", tt_a, 8'h02);
        rst = 1'b1;
        #1;
        check("t5_async_stim", stim_a, 0);
        check("t5_async_busy", busy_a, 0);
        check("t5_async_tt", tt_a, 0);
        check("t5_async_mask", mask_a, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 50; j++) begin
            @(posedge clk);
            #2;
            check("t5_no_done", done_a, 0);
        end
        start_sweep_a(8'hEA, k);
        wait_done(0, t);
        check("t5_latency", t - k, 40);
        check("t5_pass", pass_a, 1);
        check("t5_tt", tt_a, 8'hEA);

        @(negedge clk);
        exp_tt_b = 4'h6;
        start_b  = 1'b1;
        @(negedge clk);
        k = cyc;
        wait_done(1, t);
        check("t6_latency", t - k, 8);
        check("t6_pass", pass_b, 1);
        check("t6_tt", tt_b, 4'h6);
        check("t6_mask", mask_b, 4'h0);
        check("t6_cnt", cnt_b, 0);
        check("t6_busy_at_done", busy_b, 0);
        @(posedge clk);
        #2;
        check("t6_b2b_busy", busy_b, 1);
        check("t6_b2b_done", done_b, 0);
        check("t6_b2b_pass_clr", pass_b, 0);
        wait_done(1, t2);
        check("t6_b2b_latency", t2 - t, 9);
        check("t6_b2b_pass", pass_b, 1);
        @(negedge clk);
        start_b = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Hardware response checker for small combinational Boolean function blocks. On a start request it sweeps every input combination onto the function under test, waits a settle interval, captures the function output into a truth-table register, and compares the result against an expected truth table. It sits beside a Boolean function module in lab top levels and self-test wrappers. It is the response-reading counterpart of our stimulus-driving testbenches, and it reports pass/fail together with a per-vector mismatch mask.

## Interface
- `N_IN`, default 3: number of function inputs; the truth table is 2**N_IN bits wide.
- `SETTLE_CYCLES`, default 4: clock cycles each vector is held before sampling. Legal range is ≥1; 0 is illegal.
- `clk`  in  1: the single clock; all logic is on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request a sweep; accepted only in IDLE.
- `exp_tt`  in  2**N_IN: expected truth table, latched on an accepted start.
- `f_in`  in  1: output F of the function under test.
- `stim`  out  N_IN: input vector to the function under test; MSB = A, LSB = last input (C for N_IN=3).
- `busy`  out  1: high while a sweep is in progress.
- `done`  out  1: one-cycle pulse at sweep completion.
- `pass`  out  1: captured table equals the expected table; valid from `done` until the next accepted start.
- `tt_out`  out  2**N_IN: captured truth table; bit i = F sampled with `stim`==i.
- `err_mask`  out  2**N_IN: `tt_out` XOR latched `exp_tt`.
- `err_count`  out  N_IN+1: number of set bits in `err_mask`.

## Operation
- States:
  - IDLE: accepts `start`.
  - SETTLE: holds the current vector while the settle counter runs.
  - SAMPLE: captures `f_in`.
- IDLE → SETTLE on `start`:
  - latch `exp_tt`;
  - clear `tt_out`, `err_mask`, `err_count` and `pass`;
  - set `stim`=0 and the settle counter to 0;
  - set `busy`=1.
- SETTLE: increment the settle counter. SETTLE → SAMPLE when the counter reaches SETTLE_CYCLES-1.
- SAMPLE, with index i = `stim`:
  - `tt_out[i]` ← `f_in`;
  - `err_mask[i]` ← `f_in` XOR `exp[i]`;
  - `err_count` increments on a mismatch.
  - If i < 2**N_IN-1: increment `stim`, clear the settle counter, go to SETTLE.
  - Otherwise go to IDLE with `busy`=0, `done`=1 and `stim`=0. `pass`=1 iff no mismatch occurred, including the final vector.
- `start` while busy: ignored, no restart.
- `start` held high in IDLE: each IDLE cycle with `start`=1 starts a new sweep.
- `f_in` is used directly with no synchronizer; the function under test is combinational on `stim`, which is driven from a register in this block.
- `err_count` cannot overflow: its maximum is 2**N_IN, which fits in N_IN+1 bits.

## Timing
- Reset values: state IDLE, and every output is 0 (`stim`, `busy`, `done`, `pass`, `tt_out`, `err_mask`, `err_count`).
- Reset mid-sweep aborts immediately: all outputs go to 0 and no `done` is produced.
- Start accepted at edge k:
  - vector i is applied at edge k+i·(SETTLE_CYCLES+1);
  - vector i is sampled at edge k+(i+1)·(SETTLE_CYCLES+1)-… more precisely, at edge k+(i+1)·(SETTLE_CYCLES+1).
- The results registers and `done` update at the final sample edge, k+2**N_IN·(SETTLE_CYCLES+1). With the defaults this is 40 cycles after start.
- `done` is high for exactly one cycle. `busy` falls on the same edge that `done` rises.
- The earliest next start is accepted on the edge after `done` rises.

## Structure
- Package `truth_table_pkg`: state enum typedef (IDLE, SETTLE, SAMPLE) and default constants for N_IN and SETTLE_CYCLES.
- Sub-module `settle_timer`: clear/enable counter parameterised by SETTLE_CYCLES, with an `expired` output.
- Top level: FSM, `stim` counter, capture and compare registers.

## Test plan
- F = A&B | C (expected 8'hEA), exp_tt=8'hEA, start → `done` 40 cycles later; `pass`=1, `tt_out`=8'hEA, `err_mask`=0, `err_count`=0.
- Same function, exp_tt=8'hE8 → `pass`=0, `err_mask`=8'h02, `err_count`=1. Also check `stim` steps 0..7, each value held 5 cycles.
- F stuck at 1, exp_tt=8'h00 → `tt_out`=8'hFF, `err_count`=8, `pass`=0.
- Pulse `start` at cycle 10 of a sweep → ignored; `done` still at cycle 40, results unchanged.
- Assert `rst` at cycle 17 → all outputs 0 asynchronously, no `done`. A new start after release yields a full, correct 40-cycle sweep.
- SETTLE_CYCLES=1, N_IN=2, F = A XOR B, exp_tt=4'h6 → `done` after 8 cycles, `pass`=1. Then hold `start` high: a back-to-back sweep begins on the edge after `done`.
